pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage RV32 pipeline. Drives stall/flush of the F/D/E/M/W pipeline
//  registers and the E-stage operand forwarding selects. Resolves load-use, taken-branch and multi-cycle
//  data-memory hazards. Flags a stuck data memory via a timeout. Sits beside the datapath; pure control, no data.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before entering TIMEOUT (>=1)
//  CNT_W        32   width of stall-cycle performance counter
// PORTS
//  iClk           in   1      clock, all state on posedge
//  iRst           in   1      synchronous, active-high reset
//  iRs1D/iRs2D    in   5      source regs of instr in D
//  iRs1E/iRs2E    in   5      source regs of instr in E
//  iDestRegE      in   5      dest reg of instr in E
//  iResultSrcE    in   3      result-source select of instr in E (RESULT_MEM = load)
//  iRegWriteEnE   in   1      E instr writes register file
//  iPCSrcE        in   1      taken branch/jump resolved in E
//  iDestRegM      in   5      dest reg in M;  iRegWriteEnM in 1: M instr writes RF
//  iDestRegW      in   5      dest reg in W;  iRegWriteEnW in 1: W instr writes RF
//  iMemReqM       in   1      M instr accesses data memory
//  iMemReadyM     in   1      data memory completes access this cycle
//  oStallF/D/E/M  out  1 each hold the corresponding pipeline register
//  oFlushD/E/W    out  1 each load a bubble (all control zero) into that register
//  oForwardAE     out  2      00 RF, 01 W result, 10 M ALU result (operand A)
//  oForwardBE     out  2      same encoding, operand B
//  oMemTimeout    out  1      sticky: data memory exceeded MEM_TIMEOUT
//  oStallCount    out  CNT_W  count of cycles with oStallF=1, saturating
// BEHAVIOUR
//  Reset (iRst=1, synchronous): state<=RUN, wait counter<=0, oStallCount<=0, oMemTimeout<=0. While iRst high:
//   oFlushD=oFlushE=oFlushW=1, all stalls 0, forwards 00.
//  Forwarding (combinational, every state): A: 10 if iRegWriteEnM && iDestRegM!=0 && iDestRegM==iRs1E;
//   else 01 if iRegWriteEnW && iDestRegW!=0 && iDestRegW==iRs1E; else 00. M has priority over W. B same with iRs2E.
//  Hazard terms: memWait = iMemReqM && !iMemReadyM; loadUse = iResultSrcE==RESULT_MEM && iRegWriteEnE &&
//   iDestRegE!=0 && (iDestRegE==iRs1D || iDestRegE==iRs2D); branch = iPCSrcE.
//  FSM states RUN, MEM_WAIT, TIMEOUT. Outputs combinational from state+inputs, priority top-down:
//   TIMEOUT: oStallF/D/E/M=1, oFlushW=1, oFlushD/E=0; stays until iRst.
//   memWait (RUN or MEM_WAIT): oStallF/D/E/M=1, oFlushW=1, D/E flush suppressed (branch/load-use held
//    in E and re-evaluated after release). RUN->MEM_WAIT next cycle; wait counter increments per MEM_WAIT cycle.
//   MEM_WAIT && iMemReadyM: release same cycle (no stall), evaluate branch/loadUse normally, ->RUN, counter<=0.
//   MEM_WAIT with counter==MEM_TIMEOUT-1 and still !iMemReadyM: ->TIMEOUT, oMemTimeout<=1.
//   branch: oFlushD=1, oFlushE=1, no stalls (overrides loadUse; D instr is wrong-path).
//   loadUse: oStallF=1, oStallD=1, oFlushE=1 for exactly one cycle (load advances to M, then forwarding 01 via W).
//   otherwise all stalls/flushes 0.
//  Stall counter: +1 each non-reset cycle with oStallF=1; saturates at all-ones, no wrap.
//  x0 never triggers forwarding or load-use. Reset mid-MEM_WAIT returns to RUN next edge, counters cleared.
// STRUCTURE
//  pipeline_pkg: RESULT_MEM (3'b001) and other ResultSrc encodings; fwd_sel_t enum {FWD_RF,FWD_W,FWD_M};
//   hctrl_state_t enum {RUN,MEM_WAIT,TIMEOUT}.
//  Sub-module: forward_sel (combinational, one instance per operand: rsE, dest/we of M and W -> fwd_sel_t).
//  Top holds FSM, wait counter, stall counter, hazard priority mux.
// TESTING
//  1 Rs1E=5, DestRegM=5 WEnM=1, DestRegW=5 WEnW=1 -> oForwardAE=10; DestRegM=0 same case -> 01 from W.
//  2 lw x3 in E (ResultSrcE=001), Rs2D=3 -> 1 cycle oStallF=oStallD=oFlushE=1; next cycle all 0, oStallCount=1.
//  3 iPCSrcE=1 with concurrent loadUse -> oFlushD=oFlushE=1, oStallF=0.
//  4 iMemReqM=1, iMemReadyM=0 for 3 cycles then 1 -> stalls F/D/E/M + oFlushW for 3 cycles, released on 4th, state RUN.
//  5 MEM_TIMEOUT=4, ready never asserted -> TIMEOUT after 4 wait cycles, oMemTimeout=1 sticky; iRst clears all.
//  6 iRst asserted during MEM_WAIT -> flushes D/E/W high, next cycle RUN, oStallCount=0, no stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared ResultSrc encodings, forwarding select and hazard FSM state types
package pipeline_pkg;
  localparam logic [2:0] RESULT_ALU = 3'b000;
  localparam logic [2:0] RESULT_MEM = 3'b001;
  localparam logic [2:0] RESULT_PC4 = 3'b010;
  localparam logic [2:0] RESULT_IMM = 3'b011;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, TIMEOUT = 2'b10} hctrl_state_t;
endpackage

// File: rtl/forward_sel.sv
// forward_sel: E-stage operand source (iRsE vs M/W dest+we) -> oSel, M over W, x0 never forwarded
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] iRsE,
  input  logic [4:0] iDestRegM,
  input  logic       iRegWriteEnM,
  input  logic [4:0] iDestRegW,
  input  logic       iRegWriteEnW,
  output fwd_sel_t   oSel
);
  logic hit_m, hit_w;
  always_comb begin
    hit_m = iRegWriteEnM && iDestRegM != 5'd0 && iDestRegM == iRsE;
    hit_w = iRegWriteEnW && iDestRegW != 5'd0 && iDestRegW == iRsE;
    oSel  = hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for the 5-stage pipeline with data-memory timeout and stall counter
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
)(
  input  logic             iClk,
  input  logic             iRst,
  input  logic [4:0]       iRs1D,
  input  logic [4:0]       iRs2D,
  input  logic [4:0]       iRs1E,
  input  logic [4:0]       iRs2E,
  input  logic [4:0]       iDestRegE,
  input  logic [2:0]       iResultSrcE,
  input  logic             iRegWriteEnE,
  input  logic             iPCSrcE,
  input  logic [4:0]       iDestRegM,
  input  logic             iRegWriteEnM,
  input  logic [4:0]       iDestRegW,
  input  logic             iRegWriteEnW,
  input  logic             iMemReqM,
  input  logic             iMemReadyM,
  output logic             oStallF,
  output logic             oStallD,
  output logic             oStallE,
  output logic             oStallM,
  output logic             oFlushD,
  output logic             oFlushE,
  output logic             oFlushW,
  output logic [1:0]       oForwardAE,
  output logic [1:0]       oForwardBE,
  output logic             oMemTimeout,
  output logic [CNT_W-1:0] oStallCount
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);
  hctrl_state_t state, state_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic set_to, mem_wait, load_use;
  fwd_sel_t fwd_a, fwd_b;
  forward_sel u_fwd_a (
    .iRsE(iRs1E), .iDestRegM(iDestRegM), .iRegWriteEnM(iRegWriteEnM),
    .iDestRegW(iDestRegW), .iRegWriteEnW(iRegWriteEnW), .oSel(fwd_a)
  );
  forward_sel u_fwd_b (
    .iRsE(iRs2E), .iDestRegM(iDestRegM), .iRegWriteEnM(iRegWriteEnM),
    .iDestRegW(iDestRegW), .iRegWriteEnW(iRegWriteEnW), .oSel(fwd_b)
  );
  assign oForwardAE = iRst ? FWD_RF : fwd_a;
  assign oForwardBE = iRst ? FWD_RF : fwd_b;
  assign mem_wait = iMemReqM && !iMemReadyM;
  assign load_use = iResultSrcE == RESULT_MEM && iRegWriteEnE && iDestRegE != 5'd0 &&
                    (iDestRegE == iRs1D || iDestRegE == iRs2D);
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    set_to     = 1'b0;
    {oStallF, oStallD, oStallE, oStallM} = 4'b0000;
    {oFlushD, oFlushE, oFlushW} = 3'b000;
    if (iRst) begin
      {oFlushD, oFlushE, oFlushW} = 3'b111;
    end else if (state == TIMEOUT) begin
      {oStallF, oStallD, oStallE, oStallM, oFlushW} = 5'b11111;
    end else if (mem_wait) begin
      {oStallF, oStallD, oStallE, oStallM, oFlushW} = 5'b11111;
      if (state == RUN) state_n = MEM_WAIT;
      else if (wait_cnt == LAST) begin
        state_n = TIMEOUT;
        set_to  = 1'b1;
      end else wait_cnt_n = wait_cnt + 1'b1;
    end else begin
      state_n    = RUN;
      wait_cnt_n = '0;
      if (iPCSrcE) {oFlushD, oFlushE} = 2'b11;
      else if (load_use) {oStallF, oStallD, oFlushE} = 3'b111;
    end
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      oMemTimeout <= 1'b0;
      oStallCount <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (set_to) oMemTimeout <= 1'b1;
      if (oStallF && !(&oStallCount)) oStallCount <= oStallCount + 1'b1;
    end
  end
endmodule
